// File: rtl/idu_stage_ctrl.sv
// Decode-stage controller between IFU and EXU: decodes and registers fields, with a one-entry skid buffer.
// Optional performance counters are enabled by defining IDU_PERF_EN.
module idu_stage_ctrl #(
    parameter int unsigned XLEN         = 32,
    parameter logic [31:0] RESET_PC_TAG = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_illegal
`ifdef IDU_PERF_EN
    ,
    output logic [31:0]     perf_decoded,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned TYPE_W = 3;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned PERF_W = 32;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_MISC   = 5'b00011;
    localparam logic [4:0] OPC_OPIMM  = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef enum logic [TYPE_W-1:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   imm;
        logic [TYPE_W-1:0] typ;
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic [F3_W-1:0]   funct3;
        logic              illegal;
    } dec_t;

    // Immediate generator: driven by opcode[6:2] and inst[31:7] only.
    function automatic logic [31:0] imm_gen(input logic [4:0] opc, input logic [31:7] ib);
        logic [31:0] imm;
        imm = 32'h0;
        case (opc)
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_MISC:
                imm = {{20{ib[31]}}, ib[31:20]};
            OPC_STORE:
                imm = {{20{ib[31]}}, ib[31:25], ib[11:7]};
            OPC_BRANCH:
                imm = {{19{ib[31]}}, ib[31], ib[7], ib[30:25], ib[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:
                imm = {ib[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{ib[31]}}, ib[31], ib[19:12], ib[20], ib[30:21], 1'b0};
            default:
                imm = 32'h0;
        endcase
        return imm;
    endfunction

    state_e      state_q, state_d;
    dec_t        main_q, main_d;
    dec_t        skid_q, skid_d;
    logic        in_ready_q, in_ready_d;
    logic        out_valid_q, out_valid_d;

    fmt_e        fmt;
    logic [31:0] imm_raw;
    dec_t        dec;
    logic        accept;
    logic        drain;

    // Format classification; anything unknown or non-32-bit encoding is illegal.
    always_comb begin
        fmt = FMT_ILL;
        case (in_inst[6:2])
            OPC_OP:                                               fmt = FMT_R;
            OPC_LOAD, OPC_OPIMM, OPC_JALR, OPC_SYSTEM, OPC_MISC:  fmt = FMT_I;
            OPC_STORE:                                            fmt = FMT_S;
            OPC_BRANCH:                                           fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:                                   fmt = FMT_U;
            OPC_JAL:                                              fmt = FMT_J;
            default:                                              fmt = FMT_ILL;
        endcase
        if (in_inst[1:0] != 2'b11) begin
            fmt = FMT_ILL;
        end
    end

    assign imm_raw = imm_gen(in_inst[6:2], in_inst[31:7]);

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.typ     = fmt;
        dec.illegal = (fmt == FMT_ILL);
        dec.imm     = (fmt == FMT_ILL) ? '0 : XLEN'(imm_raw);
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.rd      = in_inst[11:7];
        dec.funct3  = in_inst[14:12];
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Occupancy FSM: next state and data movement between input, skid and main.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = dec;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_d  = dec;
                    end else if (accept) begin
                        skid_d  = dec;
                        state_d = TWO;
                    end else if (drain) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (drain) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= EMPTY;
            main_q         <= '0;
            main_q.pc      <= XLEN'(RESET_PC_TAG);
            skid_q         <= '0;
            in_ready_q     <= 1'b0;
            out_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            main_q         <= main_d;
            skid_q         <= skid_d;
            in_ready_q     <= in_ready_d;
            out_valid_q    <= out_valid_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_pc      = main_q.pc;
    assign out_imm     = main_q.imm;
    assign out_type    = main_q.typ;
    assign out_rs1     = main_q.rs1;
    assign out_rs2     = main_q.rs2;
    assign out_rd      = main_q.rd;
    assign out_funct3  = main_q.funct3;
    assign out_illegal = main_q.illegal;

`ifdef IDU_PERF_EN
    logic [PERF_W-1:0] perf_decoded_q, perf_decoded_d;
    logic [PERF_W-1:0] perf_stall_q, perf_stall_d;

    // Free-running event counters; wrap naturally and ignore flush.
    always_comb begin
        perf_decoded_d = perf_decoded_q;
        perf_stall_d   = perf_stall_q;
        if (drain) begin
            perf_decoded_d = perf_decoded_q + PERF_W'(1);
        end
        if (out_valid_q && !out_ready) begin
            perf_stall_d = perf_stall_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_decoded_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_decoded_q <= perf_decoded_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_decoded = perf_decoded_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_idu_stage_ctrl.sv
// Scoreboard bench for idu_stage_ctrl: driver pushes hand-decoded expectations, negedge monitor pops on drain.
module tb_idu_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [2:0]  out_type;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic        out_illegal;
`ifdef IDU_PERF_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_stall;
`endif

    idu_stage_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_imm     (out_imm),
        .out_type    (out_type),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_rd      (out_rd),
        .out_funct3  (out_funct3),
        .out_illegal (out_illegal)
`ifdef IDU_PERF_EN
        ,
        .perf_decoded(perf_decoded),
        .perf_stall  (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [2:0]  typ;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   drains   = 0;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] typ,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [2:0] f3, input logic ill);
        exp_t e;
        e = {pc, imm, typ, rs1, rs2, rd, f3, ill};
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    // Monitor: check every drained entry against the scoreboard and hold-stability under back-pressure.
    exp_t act_e, prev_e, head_e;
    logic prev_hold = 1'b0;
    always @(negedge clk) begin
        act_e = {out_pc, out_imm, out_type, out_rs1, out_rs2, out_rd, out_funct3, out_illegal};
        if (!rst && out_valid) begin
            if (prev_hold) begin
                checks++;
                if (act_e !== prev_e) begin
                    failures++;
                    $display("FAIL hold_stable actual_pc=%h imm=%h required_pc=%h imm=%h",
                             act_e.pc, act_e.imm, prev_e.pc, prev_e.imm);
                end
            end
            if (out_ready) begin
                drains++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output actual_pc=%h required=none", act_e.pc);
                end else begin
                    head_e = exp_q.pop_front();
                    if (act_e !== head_e) begin
                        failures++;
                        $display("FAIL drain actual pc=%h imm=%h type=%0d rs1=%0d rs2=%0d rd=%0d f3=%0d ill=%0d required pc=%h imm=%h type=%0d rs1=%0d rs2=%0d rd=%0d f3=%0d ill=%0d",
                                 act_e.pc, act_e.imm, act_e.typ, act_e.rs1, act_e.rs2, act_e.rd, act_e.f3, act_e.ill,
                                 head_e.pc, head_e.imm, head_e.typ, head_e.rs1, head_e.rs2, head_e.rd, head_e.f3, head_e.ill);
                    end
                end
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                prev_e    = act_e;
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    // Wait (bounded) for the handshake of the word currently driven, then record its expectation.
    task automatic wait_acc(input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout pc=%h actual_ready=0 required=1", e.pc);
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] inst, input exp_t e);
        in_valid = 1'b1;
        in_pc    = pc;
        in_inst  = inst;
        wait_acc(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int drains_before;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        in_pc     = 32'h0;
        flush     = 1'b0;
        out_ready = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_type", 32'(out_type), 32'd0);
        chk("rst_out_illegal", 32'(out_illegal), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Single instruction latency and field decode
        out_ready = 1'b1;
        issue(32'h0000_0100, 32'hFFF0_0093, mk(32'h100, 32'hFFFF_FFFF, 3'd1, 5'd0, 5'd31, 5'd1, 3'd0, 1'b0));
        @(negedge clk);
        chk("latency_valid", 32'(out_valid), 32'd1);
        tick(1);

        // Back-to-back formats
        issue(32'h0000_0104, 32'h0020_A423, mk(32'h104, 32'h0000_0008, 3'd2, 5'd1, 5'd2, 5'd8, 3'd2, 1'b0));
        issue(32'h0000_0108, 32'h1234_52B7, mk(32'h108, 32'h1234_5000, 3'd4, 5'd8, 5'd3, 5'd5, 3'd5, 1'b0));
        issue(32'h0000_010C, 32'hFFDF_F06F, mk(32'h10C, 32'hFFFF_FFFC, 3'd5, 5'd31, 5'd29, 5'd0, 3'd7, 1'b0));
        issue(32'h0000_0110, 32'hFE00_0EE3, mk(32'h110, 32'hFFFF_FFFC, 3'd3, 5'd0, 5'd0, 5'd29, 3'd0, 1'b0));
        issue(32'h0000_0114, 32'h0020_81B3, mk(32'h114, 32'h0000_0000, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0));
        issue(32'h0000_0118, 32'h0000_007B, mk(32'h118, 32'h0000_0000, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1));
        tick(3);

        // Back-pressure: two accepted, third blocked, then 1/cycle drain in order
        out_ready = 1'b0;
        issue(32'h8000_0000, 32'hFFF0_0093, mk(32'h8000_0000, 32'hFFFF_FFFF, 3'd1, 5'd0, 5'd31, 5'd1, 3'd0, 1'b0));
        issue(32'h8000_0004, 32'h1234_52B7, mk(32'h8000_0004, 32'h1234_5000, 3'd4, 5'd8, 5'd3, 5'd5, 3'd5, 1'b0));
        in_valid = 1'b1;
        in_pc    = 32'h8000_0008;
        in_inst  = 32'h0020_A423;
        repeat (3) begin
            @(negedge clk);
            chk("blocked_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        drains_before = drains;
        out_ready = 1'b1;
        wait_acc(mk(32'h8000_0008, 32'h0000_0008, 3'd2, 5'd1, 5'd2, 5'd8, 3'd2, 1'b0));
        tick(1);
        chk("drain_rate", 32'(drains - drains_before), 32'd3);
        tick(2);

        // Flush in TWO with a pending word: everything dropped
        out_ready = 1'b0;
        issue(32'h0000_0200, 32'h0020_81B3, mk(32'h200, 32'h0, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0));
        issue(32'h0000_0204, 32'hFE00_0EE3, mk(32'h204, 32'hFFFF_FFFC, 3'd3, 5'd0, 5'd0, 5'd29, 3'd0, 1'b0));
        in_valid = 1'b1;
        in_pc    = 32'h0000_0208;
        in_inst  = 32'h1234_52B7;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_two_out_valid", 32'(out_valid), 32'd0);
        chk("flush_two_in_ready", 32'(in_ready), 32'd1);
        tick(1);
        out_ready = 1'b1;
        tick(3);
        issue(32'h0000_0300, 32'h0000_0000, mk(32'h300, 32'h0, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1));
        tick(2);

        // Flush in ONE beats a simultaneous accept
        out_ready = 1'b0;
        issue(32'h0000_0400, 32'hFFDF_F06F, mk(32'h400, 32'hFFFF_FFFC, 3'd5, 5'd31, 5'd29, 5'd0, 3'd7, 1'b0));
        in_valid = 1'b1;
        in_pc    = 32'h0000_0404;
        in_inst  = 32'hFFF0_0093;
        flush    = 1'b1;
        tick(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_one_out_valid", 32'(out_valid), 32'd0);
        tick(1);
        out_ready = 1'b1;
        tick(3);

        // Flush with a simultaneous drain: the drained entry counts as consumed
        issue(32'h0000_0500, 32'h0020_A423, mk(32'h500, 32'h8, 3'd2, 5'd1, 5'd2, 5'd8, 3'd2, 1'b0));
        drains_before = drains;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        chk("flush_drain_consumed", 32'(drains - drains_before), 32'd1);
        exp_q.delete();
        @(negedge clk);
        chk("flush_drain_out_valid", 32'(out_valid), 32'd0);
        tick(2);

        // Reset mid-operation discards held entries
        out_ready = 1'b0;
        issue(32'h0000_0600, 32'hFFF0_0093, mk(32'h600, 32'hFFFF_FFFF, 3'd1, 5'd0, 5'd31, 5'd1, 3'd0, 1'b0));
        issue(32'h0000_0604, 32'h1234_52B7, mk(32'h604, 32'h1234_5000, 3'd4, 5'd8, 5'd3, 5'd5, 3'd5, 1'b0));
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        chk("midrst_out_pc", out_pc, 32'h0);
        tick(1);
        rst = 1'b0;
        tick(1);

`ifdef IDU_PERF_EN
        chk("perf_decoded_reset", perf_decoded, 32'd0);
        chk("perf_stall_reset", perf_stall, 32'd0);
        out_ready = 1'b0;
        issue(32'h0000_0700, 32'h0020_81B3, mk(32'h700, 32'h0, 3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0));
        tick(3);
        out_ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            issue(32'h0000_0700 + 32'(4 * i), 32'h0000_0000,
                  mk(32'h0000_0700 + 32'(4 * i), 32'h0, 3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 1'b1));
        end
        tick(3);
        chk("perf_decoded", perf_decoded, 32'd5);
        chk("perf_stall", perf_stall, 32'd3);
        rst = 1'b1;
        @(negedge clk);
        chk("perf_decoded_clear", perf_decoded, 32'd0);
        chk("perf_stall_clear", perf_stall, 32'd0);
        tick(1);
        rst = 1'b0;
        tick(1);
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/idu_stage_ctrl.md
Name: idu_stage_ctrl

Overview:
Decode-stage controller for the NPC pipeline, between IFU and EXU. Accepts fetched instruction/PC over a valid/ready handshake and drives the immediate generator with opcode[6:2]/inst[31:7]. Registers the decoded fields and classifies the instruction format. Buffers one extra entry (skid) so in_ready is a register output and the stage sustains 1 instr/cycle under back-pressure.

Parameters:
XLEN, 32, data/PC width; only 32 is supported.
RESET_PC_TAG, 32'h0, value driven on out_pc while out_valid=0 after reset.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  IFU presents instruction
in_ready  output  1  stage can accept; registered, equals ~skid_valid
in_inst  input  32  instruction word
in_pc  input  32  instruction PC
flush  input  1  redirect from EXU; kill all held entries
out_valid  output  1  decoded entry available
out_ready  input  1  EXU accepts
out_pc  output  32  PC of entry
out_imm  output  32  sign/format-extended immediate
out_type  output  3  0=R,1=I,2=S,3=B,4=U,5=J,7=illegal
out_rs1  output  5  inst[19:15]
out_rs2  output  5  inst[24:20]
out_rd  output  5  inst[11:7]
out_funct3  output  3  inst[14:12]
out_illegal  output  1  unsupported encoding

Behaviour:
- Reset (async): out_valid=0, skid_valid=0, all out_* data=0 (out_pc=RESET_PC_TAG); in_ready=0 while rst high, 1 on first edge after release.
- Decode (combinational on the incoming word, registered on capture): internal imm_gen instance fed in_inst[6:2], in_inst[31:7].
- Classification by inst[6:2]: 01100 R; 00000/00100/11001/11100/00011 I; 01000 S; 11000 B; 01101/00101 U; 11011 J. Anything else, or inst[1:0]!=2'b11 -> type 7, out_illegal=1, out_imm=0; entry still propagates (EXU raises exception).
- Storage: main register (out_*) + one skid register; states EMPTY (no valid), ONE (main valid), TWO (main+skid valid).
- Accept = in_valid & in_ready; drain = out_valid & out_ready.
- EMPTY: accept -> ONE, main loads; out_valid next cycle (latency 1).
- ONE: accept&drain -> ONE, main reloads; accept&~drain -> TWO, new entry into skid; ~accept&drain -> EMPTY.
- TWO: in_ready=0; drain -> ONE, skid moves to main; else hold.
- out_* stable while out_valid&~out_ready (no change until drain).
- Ordering strictly FIFO; no entry lost or duplicated.
- flush: next cycle -> EMPTY, in_ready=1; flush wins over simultaneous accept (incoming word dropped) and over drain (drain in same cycle still counts as consumed by EXU).
- rst mid-operation: all held entries discarded immediately.

Optional Feature:
IDU_PERF_EN: adds outputs perf_decoded[31:0] (increments on each drain) and perf_stall[31:0] (increments each cycle out_valid&~out_ready); both wrap at 2^32, reset to 0, unaffected by flush. Without the macro these ports and counters do not exist.

Test Plan:
- in 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, type=1, imm=0xFFFFFFFF, rd=1, rs1=0.
- 0x0020A423 (sw x2,8(x1)) -> type=2, imm=0x00000008, rs1=1, rs2=2, funct3=2; then 0x123452B7 (lui x5) -> type=4, imm=0x12345000, rd=5.
- 0xFFDFF06F (jal x0,-4) -> type=5, imm=0xFFFFFFFC; 0xFE000EE3 (beq x0,x0,-4) -> type=3, imm=0xFFFFFFFC.
- out_ready=0, stream 3 instrs at PC 0x80000000/4/8 -> third blocked (in_ready=0 after 2 accepted); release out_ready -> PCs emerge in order, 1/cycle, none lost.
- State TWO, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped word never appears; 0x00000000 input -> out_illegal=1, type=7, imm=0.
- IDU_PERF_EN: 5 drains + 3 stalled cycles -> perf_decoded=5, perf_stall=3; rst clears both.
